// File: rtl/demorgan_sweep_checker.sv
// Exhaustive De Morgan self-test engine: sweeps every (A, B) pair through a
// registered gate stage, counts identity mismatches and records the first one.
module demorgan_sweep_checker #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               inject_en,
    input  logic               inject_all,
    input  logic [2*WIDTH-1:0] inject_vec,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [2*WIDTH-1:0] first_fail
);

    localparam int VW = 2 * WIDTH;
    localparam logic [VW-1:0]    LAST_VEC = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [VW-1:0]    vec;
    logic [VW-1:0]    cap_vec;
    logic             pipe_valid;
    logic [WIDTH-1:0] nor_r, nandn_r, nand_r, norn_r;

    logic [WIDTH-1:0] op_a, op_b;
    logic             fault;
    logic [WIDTH-1:0] fault_mask;
    logic             start_ok;
    logic             abort_ok;
    logic             mismatch;

    assign op_a       = vec[VW-1:WIDTH];
    assign op_b       = vec[WIDTH-1:0];
    assign fault      = inject_all || (inject_en && (vec == inject_vec));
    assign fault_mask = WIDTH'(fault);
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    assign abort_ok   = abort && ((state == S_RUN) || (state == S_DRAIN));
    assign mismatch   = pipe_valid && ((nor_r != nandn_r) || (nand_r != norn_r));

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

    // Sequencer and gate-evaluation stage; a fault flips bit 0 of the NOR result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= '0;
            cap_vec    <= '0;
            pipe_valid <= 1'b0;
            nor_r      <= '0;
            nandn_r    <= '0;
            nand_r     <= '0;
            norn_r     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        vec        <= '0;
                        pipe_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        vec        <= '0;
                        pipe_valid <= 1'b0;
                    end else begin
                        nor_r      <= ~(op_a | op_b) ^ fault_mask;
                        nandn_r    <= ~op_a & ~op_b;
                        nand_r     <= ~(op_a & op_b);
                        norn_r     <= ~op_a | ~op_b;
                        cap_vec    <= vec;
                        pipe_valid <= 1'b1;
                        vec        <= vec + 1'b1;
                        if (vec == LAST_VEC) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    state      <= abort ? S_IDLE : S_DONE;
                    pipe_valid <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    pipe_valid <= 1'b0;
                end
            endcase
        end
    end

    // Results survive an abort untouched and are only cleared by a new sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            first_fail <= '0;
        end else if (abort_ok) begin
            err_count  <= err_count;
            first_fail <= first_fail;
        end else if (start_ok) begin
            err_count  <= '0;
            first_fail <= '0;
        end else if (mismatch) begin
            if (err_count != CNT_MAX) begin
                err_count <= err_count + 1'b1;
            end
            if (err_count == '0) begin
                first_fail <= cap_vec;
            end
        end
    end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Scoreboard bench for demorgan_sweep_checker: a default-width instance and a
// 3-bit-counter instance share stimulus so saturation is seen alongside the rest.
module tb_demorgan_sweep_checker;

    localparam int WIDTH = 2;
    localparam int NVEC  = 1 << (2 * WIDTH);

    typedef struct {
        int err;
        int first;
        int err_sat;
        int first_sat;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic               inject_en;
    logic               inject_all;
    logic [2*WIDTH-1:0] inject_vec;

    logic               busy, done, pass;
    logic [15:0]        err_count;
    logic [2*WIDTH-1:0] first_fail;
    logic               busy_s, done_s, pass_s;
    logic [2:0]         err_count_s;
    logic [2*WIDTH-1:0] first_fail_s;

    int   assertions = 0;
    int   failures   = 0;
    exp_t sb[$];

    demorgan_sweep_checker #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .inject_en(inject_en), .inject_all(inject_all), .inject_vec(inject_vec),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail)
    );

    demorgan_sweep_checker #(.WIDTH(WIDTH), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .inject_en(inject_en), .inject_all(inject_all), .inject_vec(inject_vec),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_count_s), .first_fail(first_fail_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        assertions++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    // Reference: evaluate the identities on the first nvec vectors, with the fault applied.
    function automatic exp_t model(input bit en, input bit all, input int iv, input int nvec);
        exp_t e;
        int   a, b, nor_v, nandn_v, nand_v, norn_v;
        e = '{err: 0, first: 0, err_sat: 0, first_sat: 0};
        for (int v = 0; v < nvec; v++) begin
            a       = (v >> WIDTH) & 3;
            b       = v & 3;
            nor_v   = ~(a | b) & 3;
            nandn_v = (~a & ~b) & 3;
            nand_v  = ~(a & b) & 3;
            norn_v  = (~a | ~b) & 3;
            if (all || (en && v == iv)) nor_v = nor_v ^ 1;
            if (nor_v != nandn_v || nand_v != norn_v) begin
                if (e.err == 0) e.first = v;
                if (e.err < 65535) e.err++;
                if (e.err_sat == 0) e.first_sat = v;
                if (e.err_sat < 7) e.err_sat++;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit en, input bit all, input int iv,
                                 input int abort_at, input int poke_start_at);
        exp_t e;
        int   cycles;
        int   nvec;
        nvec = (abort_at > 0) ? abort_at - 2 : NVEC;
        sb.push_back(model(en, all, iv, nvec));

        @(negedge clk);
        inject_en  = en;
        inject_all = all;
        inject_vec = iv[2*WIDTH-1:0];
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("done_after_start", done, 0);
        checkOutput("err_cleared_at_start", err_count, 0);

        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            abort = (cycles == abort_at);
            start = (cycles == poke_start_at);
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;

        e = sb.pop_front();
        checkOutput("busy_cycles", cycles, (abort_at > 0) ? abort_at : NVEC + 1);
        checkOutput("done", done, (abort_at > 0) ? 0 : 1);
        checkOutput("pass", pass, (abort_at == 0 && e.err == 0) ? 1 : 0);
        checkOutput("err_count", err_count, e.err);
        checkOutput("first_fail", first_fail, e.first);
        checkOutput("sat_err_count", err_count_s, e.err_sat);
        checkOutput("sat_first_fail", first_fail_s, e.first_sat);
        inject_en  = 1'b0;
        inject_all = 1'b0;
        inject_vec = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        inject_en  = 1'b0;
        inject_all = 1'b0;
        inject_vec = '0;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err", err_count, 0);
        checkOutput("rst_first", first_fail, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean sweep with a stray start mid-run, then a single fault on vector 5.
        applyStimulus(1'b0, 1'b0, 0, 0, 5);
        applyStimulus(1'b1, 1'b0, 5, 0, 0);
        // Back-to-back restart from DONE must clear the previous error.
        applyStimulus(1'b0, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 2, 6, 0);
        checkOutput("abort_idle_done", done, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0);

        // Asynchronous reset between edges partway through a faulted sweep.
        @(negedge clk);
        inject_en  = 1'b1;
        inject_vec = 4'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("err_before_reset", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_pass", pass, 0);
        checkOutput("midrst_err", err_count, 0);
        checkOutput("midrst_first", first_fail, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        inject_en  = 1'b0;
        inject_vec = '0;
        @(negedge clk);
        checkOutput("post_reset_idle", busy, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_checker.md
# demorgan_sweep_checker

Parametrised, self-sequencing checker for De Morgan identities on WIDTH-bit operands. On a start pulse it walks every (A, B) operand pair through a registered gate-evaluation stage and compares both identity pairs: ~(A|B) vs ~A&~B, and ~(A&B) vs ~A|~B. It counts mismatches, records the first failing vector and reports pass/fail. A fault-injection port proves that the comparator can actually fail. It sits beside the combinational gate library as its built-in exhaustive test engine.

## Interface
- WIDTH, 2, bit width of each operand A and B; N = 2^(2*WIDTH) vectors per sweep
- CNT_W, 16, error counter width; the counter saturates
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; sampled only in IDLE or DONE
- abort  in  1  synchronous; returns to IDLE from RUN/DRAIN
- inject_en  in  1  enable fault on the vector matching inject_vec
- inject_all  in  1  fault on every vector; overrides inject_vec
- inject_vec  in  2*WIDTH  vector index to corrupt
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  done && err_count==0
- err_count  out  CNT_W  mismatching vectors, saturating
- first_fail  out  2*WIDTH  index of first mismatching vector; valid when err_count!=0

## Operation
- Vector index vec[2*WIDTH-1:0]: A = vec[2*WIDTH-1:WIDTH], B = vec[WIDTH-1:0].
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: go to RUN; vec, err_count and first_fail clear to 0; the pipe valid flag clears.
  - RUN: each cycle, stage 1 registers nor_r=~(A|B), nandn_r=~A&~B, nand_r=~(A&B), norn_r=~A|~B for the current vec, and vec increments. When vec==N-1 is captured, vec wraps to 0 and the FSM goes to DRAIN.
  - DRAIN: one cycle in which the final captured vector is compared. Next state is DONE.
  - DONE: holds until start or reset.
  - RUN/DRAIN + abort: go to IDLE; pipe valid clears; err_count and first_fail hold their values; done stays 0. abort is ignored in IDLE and DONE.
- Compare stage, evaluated when pipe valid is set:
  - mismatch = (nor_r != nandn_r) || (nand_r != norn_r).
  - On mismatch, err_count increments, saturating at 2^CNT_W-1.
  - If err_count was 0 before this increment, first_fail loads the captured index.
- Fault injection:
  - Active when inject_all, or when inject_en && vec==inject_vec.
  - An active fault inverts bit 0 of nor_r at capture.
  - Injection inputs are sampled per cycle during RUN.
- start in RUN or DRAIN is ignored. start and abort asserted together in RUN: abort wins.

## Timing
- Reset values: FSM in IDLE; busy=0, done=0, pass=0, err_count=0, first_fail=0, vec=0, pipe valid=0.
- Call the edge that samples start E0.
- Vector k is captured at edge E(k+1) and compared at E(k+2).
- The last vector (N-1) is captured at E(N) and compared at E(N+1).
- done and pass rise after E(N+1), i.e. N+1 cycles after start. busy falls on the same edge.
- err_count and first_fail are final on the same edge that done rises.
- Reset asserted mid-sweep immediately forces the reset values. No partial results survive.
- Restarting from DONE clears the results at E0. done drops after E0.

## Test plan
- Clean sweep, WIDTH=2 (N=16), no injection, single start pulse:
  - busy is high for exactly 17 cycles, then done=1, pass=1, err_count=0, first_fail=0.
- Single fault, inject_en=1, inject_vec=5:
  - done after 17 cycles, err_count=1, first_fail=5, pass=0.
- Saturation, CNT_W=3, inject_all=1:
  - err_count stops at 7, first_fail=0, pass=0.
- Abort, abort pulsed 6 cycles after start, with inject_vec=2 enabled:
  - FSM returns to IDLE, busy=0, done=0, err_count=1, first_fail=2.
  - A following clean start gives pass=1 after 17 cycles.
- Asynchronous reset mid-RUN (rst_n low between edges at cycle 9):
  - All outputs go to their reset values before the next edge.
  - start pulses during RUN are ignored, with no shift in done timing.
- Back-to-back: a start pulse while done=1 restarts the sweep.
  - done falls the next cycle and rises again 17 cycles after that start.
